// File: rtl/rijndael_shift_rows_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rijndael_shift_rows_if                                                  |
// | Valid/ready block stream in and out of the ShiftRows permutation stage. |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
interface rijndael_shift_rows_if #(
    parameter int NB = 4
) ();
    localparam int W = 32 * NB;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/rijndael_shift_rows.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rijndael_shift_rows                                                     |
// | Registered Rijndael ShiftRows / InvShiftRows for NB = 4, 6 or 8.        |
// | Define SHIFT_ROWS_SKID_EN for a 1-entry skid buffer (registered ready). |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module rijndael_shift_rows #(
    parameter int NB = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    rijndael_shift_rows_if.slave bus,
    output logic [15:0]          blk_cnt
);
    localparam int W = 32 * NB;

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("rijndael_shift_rows: NB must be 4, 6 or 8");
        end
    endgenerate

    logic [W-1:0] w_fwd;
    logic [W-1:0] w_inv;
    logic [W-1:0] w_perm;
    logic         w_accept;
    logic         w_xfer;

    // Pure wiring: byte (r,c) sits at [W-1-8*(4c+r) -: 8]; rows 2/3 shift one further for NB=8
    genvar r, c;
    generate
        for (r = 0; r < 4; r++) begin : g_row
            localparam int S = (NB == 8 && r >= 2) ? r + 1 : r;
            for (c = 0; c < NB; c++) begin : g_col
                localparam int CF = (c + S) % NB;
                localparam int CI = (c + NB - S) % NB;
                assign w_fwd[W-1-8*(4*c+r) -: 8] = bus.in_data[W-1-8*(4*CF+r) -: 8];
                assign w_inv[W-1-8*(4*c+r) -: 8] = bus.in_data[W-1-8*(4*CI+r) -: 8];
            end
        end
    endgenerate

    assign w_perm = bus.in_inv ? w_inv : w_fwd;

    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic [15:0]  r_blk_cnt;

    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_xfer        = r_out_valid && bus.out_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign blk_cnt       = r_blk_cnt;

`ifdef SHIFT_ROWS_SKID_EN
    logic         r_skid_valid;
    logic [W-1:0] r_skid_data;
    logic         r_in_ready;
    logic         w_skid_nxt;

    always_comb begin
        w_skid_nxt = 1'b0;
        if (r_skid_valid) begin
            w_skid_nxt = !w_xfer;
        end else begin
            w_skid_nxt = w_accept && r_out_valid && !w_xfer;
        end
    end

    assign bus.in_ready = r_in_ready;

    // Skid holds already-permuted data; it drains into the output stage on transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_in_ready   <= 1'b0;
        end else begin
            r_in_ready   <= !w_skid_nxt;
            r_skid_valid <= w_skid_nxt;
            if (r_skid_valid) begin
                if (w_xfer) begin
                    r_out_data <= r_skid_data;
                end
            end else if (w_accept) begin
                if (!r_out_valid || w_xfer) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_perm;
                end else begin
                    r_skid_data <= w_perm;
                end
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end
`else
    logic r_up;

    assign bus.in_ready = r_up && (!r_out_valid || bus.out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_up        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_up <= 1'b1;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_perm;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blk_cnt <= 16'h0000;
        end else if (w_xfer) begin
            r_blk_cnt <= r_blk_cnt + 16'h0001;
        end
    end
endmodule
`default_nettype wire

// File: doc/rijndael_shift_rows.md
RIJNDAEL_SHIFT_ROWS -- requirements
Module: rijndael_shift_rows

Interface
REQ-001 SHALL have parameter NB, default 4, meaning state columns; legal values 4, 6, 8; any other value SHALL fail elaboration.
REQ-002 SHALL derive W = 32*NB as the block width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port in_valid, input, 1 bit: input block present.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepted when in_valid and in_ready are both high.
REQ-007 SHALL have port in_data, input, W bits: state; byte (row r, column c) at bits [W-1-8*(4c+r) -: 8].
REQ-008 SHALL have port in_inv, input, 1 bit: 0 = ShiftRows, 1 = InvShiftRows; captured with in_data.
REQ-009 SHALL have port out_valid, output, 1 bit: result present.
REQ-010 SHALL have port out_ready, input, 1 bit: result consumed when out_valid and out_ready are both high.
REQ-011 SHALL have port out_data, output, W bits: permuted state, same byte layout as in_data.
REQ-012 SHALL have port blk_cnt, output, 16 bits: count of completed output transfers.

Function
REQ-013 SHALL use row shift offsets s(r) = {0,1,2,3} for NB=4 and NB=6, and {0,1,3,4} for NB=8.
REQ-014 SHALL compute forward output byte (r,c) = in(r, (c+s(r)) mod NB).
REQ-015 SHALL compute inverse output byte (r,c) = in(r, (c-s(r)) mod NB).
REQ-016 SHALL apply in_inv per block, so consecutive blocks may alternate modes with no bubble.
REQ-017 SHALL register results, with latency exactly 1 cycle from an accept to out_valid high, absent backpressure.
REQ-018 SHALL hold out_data and out_valid stable while out_valid is high and out_ready is low.
REQ-019 SHALL not let in_ready depend combinationally on in_valid.
REQ-020 SHALL sustain 1 block/cycle throughput while out_ready stays high.
REQ-021 SHALL, when an output transfer and an input accept occur in the same cycle, replace the output with the new block with no gap.
REQ-022 SHALL never drop or duplicate a block; output order SHALL equal input order.
REQ-023 SHALL increment blk_cnt by 1 per output transfer, wrapping 0xFFFF -> 0x0000.

Reset
REQ-024 SHALL, while rst_n is low at a clock edge, set out_valid=0, out_data=0, blk_cnt=0, and empty all buffer storage.
REQ-025 SHALL hold in_ready=0 during reset and drive in_ready=1 on the first cycle after rst_n goes high.
REQ-026 SHALL discard in-flight blocks on reset mid-stream; no stale block SHALL appear after reset.

Configuration
REQ-027 SHALL, with macro SHIFT_ROWS_SKID_EN defined, add a 1-entry skid buffer: in_ready is a register equal to "skid empty", and a block arriving under backpressure is held, not lost.
REQ-028 SHALL, with SHIFT_ROWS_SKID_EN undefined, use a single stage: in_ready = !out_valid || out_ready (combinational from out_ready).
REQ-029 SHALL keep data function, latency and ordering identical in both builds; only the in_ready timing differs.

Verification
REQ-030 SHALL cover: NB=4, in_inv=0, in_data=d42711aee0bf98f1b8b45de51e415230 -> one cycle later out_data=d4bf5d30e0b452aeb84111f11e2798e5.
REQ-031 SHALL cover: NB=4, in_inv=1, in_data=d4bf5d30e0b452aeb84111f11e2798e5 -> out_data=d42711aee0bf98f1b8b45de51e415230.
REQ-032 SHALL cover: NB=8, forward then inverse on byte pattern 00,01,...,1f -> inverse output equals 00..1f, and forward row 2 equals bytes from column (c+3) mod 8.
REQ-033 SHALL cover: out_ready held low 5 cycles during a 4-block burst -> out_data stable, no loss, order preserved, blk_cnt=4 at end; with SHIFT_ROWS_SKID_EN defined, in_ready falls only after the skid fills.
REQ-034 SHALL cover: rst_n low for one cycle while out_valid=1 -> next cycle out_valid=0, blk_cnt=0, and the first post-reset output is the first post-reset input.
REQ-035 SHALL cover: preload blk_cnt to 0xFFFF via 65535 transfers, then one more transfer -> blk_cnt=0x0000.
